// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums K consecutive unsigned products from the array multiplier into one
//   frame result. The frame sum is presented on a registered valid/ready port.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      synchronous active-low reset
//     flush      discard the partial frame (the pending result is kept)
//     in_valid   in_prod carries a product
//     in_ready   a beat can be taken this cycle (combinational)
//     in_prod    M+N bit unsigned product
//     out_valid  out_sum/out_ovf hold a completed frame
//     out_ready  downstream takes the result
//     out_sum    frame sum modulo 2^ACC_W
//     out_ovf    frame sum did not fit in ACC_W bits
//
//   The frame position cnt is the state:
//     state | meaning
//     IDLE  | cnt == 0, the next beat starts a new frame
//     ACCUM | 0 < cnt < K, a frame is partially summed
module product_accumulator #(
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int K     = 4,
  parameter int ACC_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [M+N-1:0]     in_prod,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic               out_ovf
);

  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

  typedef enum logic {IDLE, ACCUM} phase_t;

  phase_t             phase;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic               ovf, ovf_nxt;
  logic               accept, final_beat;
  logic [ACC_W:0]     sum;

  assign phase = (cnt == '0) ? IDLE : ACCUM;

  // Only the final beat can be held off, and only while an undrained
  // result would otherwise be overwritten.
  assign in_ready   = rst_n & ~flush & ~((cnt == LAST) & out_valid & ~out_ready);
  assign accept     = in_valid & in_ready;
  assign final_beat = accept & (cnt == LAST);

  // Extra top bit is the carry out of the accumulator.
  assign sum = {1'b0, acc} + (ACC_W + 1)'(in_prod);

  always_comb begin
    cnt_nxt = cnt;
    acc_nxt = acc;
    ovf_nxt = ovf;
    if (flush) begin
      cnt_nxt = '0;
      acc_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (accept) begin
      if (phase == IDLE) begin
        acc_nxt = ACC_W'(in_prod);
        ovf_nxt = 1'b0;
      end else begin
        acc_nxt = sum[ACC_W-1:0];
        ovf_nxt = ovf | sum[ACC_W];
      end
      cnt_nxt = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      acc <= acc_nxt;
      ovf <= ovf_nxt;
      // A loading final beat wins over a drain so frames run back to back.
      if (final_beat) begin
        out_sum   <= acc_nxt;
        out_ovf   <= ovf_nxt;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
